// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: groups the command handshake and the PS/2 pad signals of the
// host-to-device transmitter.
//
// Signals
//   tx_data    - command byte, sampled when tx_start is accepted
//   tx_start   - one-cycle send request, honoured only while busy is low
//   ps2_clk_in - raw PS2_CLK pad level
//   ps2_dat_in - raw PS2_DAT pad level
//   ps2_clk_oe - 1 pulls PS2_CLK low, 0 releases it
//   ps2_dat_oe - 1 pulls PS2_DAT low, 0 releases it
//   busy       - transfer in progress
//   tx_done    - one-cycle pulse on a valid device ACK
//   tx_error   - one-cycle pulse on NACK or timeout
//
// Modports
//   master - the environment: command source plus the pad side
//   slave  - the transmitter itself
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data,
        output tx_start,
        output ps2_clk_in,
        output ps2_dat_in,
        input  ps2_clk_oe,
        input  ps2_dat_oe,
        input  busy,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        input  ps2_clk_in,
        input  ps2_dat_in,
        output ps2_clk_oe,
        output ps2_dat_oe,
        output busy,
        output tx_done,
        output tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
//
// Sends one command byte to the keyboard over the shared open-drain PS2_CLK /
// PS2_DAT pads: request-to-send (clock inhibit, then start bit), eight data
// bits LSB first, odd parity and stop on device-generated clocks, then checks
// the device ACK bit. A receiver sharing the pads should ignore the lines
// while busy is high.
//
// Ports
//   CLOCK_50 - 50 MHz system clock
//   resetn   - asynchronous active-low reset; releases both pads immediately
//   bus      - ps2_host_tx_if.slave: tx_data/tx_start request, pad levels in,
//              pad pull-downs out, busy/tx_done/tx_error status
//
// Parameters
//   INHIBIT_CYCLES - cycles the clock is held low for request-to-send
//   TIMEOUT_CYCLES - max cycles between device clock falling edges
//   SETTLE_CYCLES  - cycles data is held low after the clock is released
//
// Optional feature (macro PS2_TX_RETRY_EN): on NACK or timeout the same byte is
// re-sent from the clock-inhibit phase, up to two retries; tx_error pulses only
// after the third failure. Without the macro the first failure ends the
// transfer with tx_error.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned SETTLE_CYCLES  = 50
) (
    input  logic         CLOCK_50,
    input  logic         resetn,
    ps2_host_tx_if.slave bus
);

    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned CntW = (TmoW > InhW) ? ((TmoW > SetW) ? TmoW : SetW)
                                                 : ((InhW > SetW) ? InhW : SetW);

    localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StSettle,
        StShift,
        StAck,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    // One phase counter serves inhibit, settle and the inter-edge timeout;
    // the phases never overlap.
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [8:0]      frame_q, frame_d;      // {parity, data}, kept intact for retries
    logic            dat_drive_q, dat_drive_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]      retry_q, retry_d;
`endif

    // Pad synchronisers; idle lines are high, so reset to 1 to avoid a false edge.
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic clk_fall;
    logic fail;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= bus.ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= bus.ps2_dat_in;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_s2_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bitcnt_q    <= '0;
            frame_q     <= '0;
            dat_drive_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitcnt_q    <= bitcnt_d;
            frame_q     <= frame_d;
            dat_drive_q <= dat_drive_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitcnt_d    = bitcnt_q;
        frame_d     = frame_q;
        dat_drive_d = dat_drive_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        fail        = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d     = retry_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.tx_start) begin
                    state_d = StInhibit;
                    cnt_d   = '0;
                    frame_d = {~^bus.tx_data, bus.tx_data};
`ifdef PS2_TX_RETRY_EN
                    retry_d = '0;
`endif
                end
            end

            StInhibit: begin
                if (cnt_q == InhibitLast) begin
                    state_d = StRts;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Single cycle with both lines low: start bit asserted before the
            // clock is released.
            StRts: begin
                state_d = StSettle;
                cnt_d   = '0;
            end

            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d     = StShift;
                    cnt_d       = '0;
                    bitcnt_d    = '0;
                    dat_drive_d = 1'b1;   // keep the start bit on the line
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StShift: begin
                if (clk_fall) begin
                    cnt_d = '0;
                    if (bitcnt_q == 4'd9) begin
                        dat_drive_d = 1'b0;   // stop bit: release data
                        state_d     = StAck;
                    end else begin
                        dat_drive_d = ~frame_q[bitcnt_q];
                        bitcnt_d    = bitcnt_q + 4'd1;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StAck: begin
                if (clk_fall) begin
                    cnt_d = '0;
                    if (!dat_s2_q) begin
                        state_d = StWaitIdle;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StWaitIdle: begin
                if (clk_s2_q && dat_s2_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (clk_fall) begin
                    cnt_d = '0;
                end else if (cnt_q == TimeoutLast) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (fail) begin
            dat_drive_d = 1'b0;
            cnt_d       = '0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                state_d = StInhibit;
                retry_d = retry_q + 2'd1;
            end else begin
                state_d = StIdle;
                error_d = 1'b1;
            end
`else
            state_d = StIdle;
            error_d = 1'b1;
`endif
        end
    end

    // Pad controls decode straight from state so an async reset releases them
    // in the same cycle.
    assign bus.ps2_clk_oe = (state_q == StInhibit) || (state_q == StRts);
    assign bus.ps2_dat_oe = (state_q == StRts) || (state_q == StSettle) ||
                            ((state_q == StShift) && dat_drive_q);
    // Pulses are registered on the transition into idle, so busy drops in the
    // same cycle the pulse is visible.
    assign bus.busy       = (state_q != StIdle);
    assign bus.tx_done    = done_q;
    assign bus.tx_error   = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
    localparam int unsigned INH        = 200;
    localparam int unsigned TMO        = 3000;
    localparam int unsigned SET        = 10;
    localparam int unsigned HALF       = 40;
    localparam int unsigned WAIT_BOUND = 20000;
`ifdef PS2_TX_RETRY_EN
    localparam int unsigned ATTEMPTS = 3;
`else
    localparam int unsigned ATTEMPTS = 1;
`endif

    typedef struct {
        logic [7:0] data;
        bit         ack_ok;
    } exp_t;

    exp_t exp_q[$];

    logic clk     = 1'b0;
    logic resetn  = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int cyc      = 0;

    ps2_host_tx_if bus_if();

    // Open-drain pads: low if either side pulls down.
    assign bus_if.ps2_clk_in = ~bus_if.ps2_clk_oe & dev_clk;
    assign bus_if.ps2_dat_in = ~bus_if.ps2_dat_oe & dev_dat;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .SETTLE_CYCLES (SET)
    ) dut (
        .CLOCK_50(clk),
        .resetn  (resetn),
        .bus     (bus_if.slave)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_if.tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (bus_if.tx_error === 1'b1) err_cnt <= err_cnt + 1;
        if (bus_if.tx_done === 1'b1 && bus_if.tx_error === 1'b1) both_cnt <= both_cnt + 1;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        return (ones % 2 == 0);
    endfunction

    task automatic push_exp(input logic [7:0] d, input bit ack_ok);
        exp_t e;
        e.data   = d;
        e.ack_ok = ack_ok;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        bus_if.tx_data  = d;
        bus_if.tx_start = 1'b1;
        @(negedge clk);
        bus_if.tx_start = 1'b0;
    endtask

    // Device model: waits for request-to-send, then generates n_falls clocks,
    // sampling data on each rising edge; optionally pulls the ACK bit low.
    task automatic dev_frame(input bit ack_low, input int n_falls, output logic [9:0] bits,
                             output int inh_len, output int last_fall, output bit ok);
        int t;
        ok = 1'b1; bits = '0; inh_len = 0; last_fall = 0; t = 0;
        while (bus_if.ps2_clk_in !== 1'b0 && t < WAIT_BOUND) begin @(negedge clk); t++; end
        while (bus_if.ps2_clk_in === 1'b0 && t < WAIT_BOUND) begin
            @(negedge clk); t++; inh_len++;
        end
        while (!(bus_if.ps2_clk_in === 1'b1 && bus_if.ps2_dat_in === 1'b0) && t < WAIT_BOUND) begin
            @(negedge clk); t++;
        end
        if (t >= WAIT_BOUND) begin
            ok = 1'b0;
            return;
        end
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < n_falls; i++) begin
            if (i == 10 && ack_low) begin
                dev_dat = 1'b0;
                repeat (HALF / 2) @(negedge clk);
            end
            dev_clk   = 1'b0;
            last_fall = cyc;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (i < 10) bits[i] = bus_if.ps2_dat_in;
            repeat (HALF) @(negedge clk);
        end
        dev_dat = 1'b1;
    endtask

    task automatic check_frame(input string tag, input logic [9:0] bits, input bit ok);
        chk({tag, "_frame_seen"}, ok, 1'b1);
        if (exp_q.size() != 0) begin
            chk({tag, "_data"}, bits[7:0], exp_q[0].data);
            chk({tag, "_parity"}, bits[8], odd_par(exp_q[0].data));
            chk({tag, "_stop"}, bits[9], 1'b1);
        end
    endtask

    task automatic finish_txn(input string tag, input int d0, input int e0);
        exp_t e;
        int   t;
        t = 0;
        while (bus_if.busy !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
        @(negedge clk);
        chk({tag, "_busy_low"}, bus_if.busy, 1'b0);
        chk({tag, "_clk_released"}, bus_if.ps2_clk_oe, 1'b0);
        chk({tag, "_dat_released"}, bus_if.ps2_dat_oe, 1'b0);
        chk({tag, "_sb_nonempty"}, (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_done_pulses"}, done_cnt - d0, e.ack_ok ? 1 : 0);
            chk({tag, "_error_pulses"}, err_cnt - e0, e.ack_ok ? 0 : 1);
        end
    endtask

    task automatic quiet_check(input string tag);
        int n;
        n = 0;
        repeat (INH + 20) begin
            @(negedge clk);
            if (bus_if.ps2_clk_oe !== 1'b0 || bus_if.busy !== 1'b0) n++;
        end
        chk({tag, "_no_extra_frame"}, n, 0);
    endtask

    initial begin
        logic [9:0] bits;
        int         inh_len, last_fall, d0, e0, t, nin;
        bit         ok;

        bus_if.tx_data  = 8'h00;
        bus_if.tx_start = 1'b0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", bus_if.ps2_clk_oe, 1'b0);
        chk("rst_dat_oe", bus_if.ps2_dat_oe, 1'b0);
        chk("rst_busy", bus_if.busy, 1'b0);
        chk("rst_done", bus_if.tx_done, 1'b0);
        chk("rst_error", bus_if.tx_error, 1'b0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // 0xED set-LEDs, ACK low
        d0 = done_cnt; e0 = err_cnt;
        push_exp(8'hED, 1'b1);
        send(8'hED);
        chk("ed_busy_on_accept", bus_if.busy, 1'b1);
        dev_frame(1'b1, 11, bits, inh_len, last_fall, ok);
        chk_range("ed_inhibit_len", inh_len, INH, INH + 2);
        check_frame("ed", bits, ok);
        finish_txn("ed", d0, e0);

        // 0xF4 with a second request while busy: ignored, not queued
        d0 = done_cnt; e0 = err_cnt;
        push_exp(8'hF4, 1'b1);
        send(8'hF4);
        repeat (5) @(negedge clk);
        send(8'h00);
        dev_frame(1'b1, 11, bits, inh_len, last_fall, ok);
        check_frame("f4", bits, ok);
        finish_txn("f4", d0, e0);
        quiet_check("f4");

        // 0xFF: the next request after tx_done is accepted
        d0 = done_cnt; e0 = err_cnt;
        push_exp(8'hFF, 1'b1);
        send(8'hFF);
        dev_frame(1'b1, 11, bits, inh_len, last_fall, ok);
        check_frame("ff", bits, ok);
        finish_txn("ff", d0, e0);

        // NACK: ACK bit left high
        d0 = done_cnt; e0 = err_cnt; nin = 0;
        push_exp(8'h55, 1'b0);
        send(8'h55);
        for (int a = 0; a < int'(ATTEMPTS); a++) begin
            dev_frame(1'b0, 11, bits, inh_len, last_fall, ok);
            if (ok) nin++;
            check_frame("nack", bits, ok);
        end
        chk("nack_inhibit_phases", nin, ATTEMPTS);
        finish_txn("nack", d0, e0);
        quiet_check("nack");

        // Timeout: device stops clocking after bit 4
        d0 = done_cnt; e0 = err_cnt;
        push_exp(8'hED, 1'b0);
        send(8'hED);
        for (int a = 0; a < int'(ATTEMPTS); a++) begin
            dev_frame(1'b1, 5, bits, inh_len, last_fall, ok);
            chk("tmo_frame_seen", ok, 1'b1);
            chk("tmo_bits", bits[4:0], 5'b01101);
        end
        t = 0;
        while (bus_if.tx_error !== 1'b1 && t < WAIT_BOUND) begin @(negedge clk); t++; end
        // Nominal TMO plus three cycles of sync/edge/pulse latency, +/-3.
        chk_range("tmo_error_delay", cyc - last_fall, TMO, TMO + 6);
        chk("tmo_clk_oe", bus_if.ps2_clk_oe, 1'b0);
        chk("tmo_dat_oe", bus_if.ps2_dat_oe, 1'b0);
        finish_txn("tmo", d0, e0);

        // Reset held low mid-SHIFT
        send(8'h00);
        dev_frame(1'b1, 3, bits, inh_len, last_fall, ok);
        chk("rstmid_reached_shift", ok, 1'b1);
        chk("rstmid_pre_dat_oe", bus_if.ps2_dat_oe, 1'b1);
        d0 = done_cnt; e0 = err_cnt;
        resetn = 1'b0;
        #1;
        chk("rstmid_clk_oe", bus_if.ps2_clk_oe, 1'b0);
        chk("rstmid_dat_oe", bus_if.ps2_dat_oe, 1'b0);
        chk("rstmid_busy", bus_if.busy, 1'b0);
        repeat (4) @(negedge clk);
        chk("rstmid_no_done", done_cnt - d0, 0);
        chk("rstmid_no_error", err_cnt - e0, 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        chk("never_done_and_error", both_cnt, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
